// File: rtl/asip_isa_pkg.sv
// Shared ISA definitions for the ID-stage issue controller.
// Contents: opcode enum, instruction field bit positions, func bit indices,
// ext_selector encodings and the issue FSM state enum.
package asip_isa_pkg;

  typedef enum logic [2:0] {
    OP_ALU = 3'b000,
    OP_CMP = 3'b001,
    OP_LDR = 3'b010,
    OP_STR = 3'b011,
    OP_JEQ = 3'b100,
    OP_JNE = 3'b101,
    OP_JMP = 3'b110,
    OP_NOP = 3'b111
  } opcode_e;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 29;
  localparam int unsigned RF_MSB = 28;
  localparam int unsigned RF_LSB = 24;
  localparam int unsigned RA_MSB = 23;
  localparam int unsigned RA_LSB = 19;
  localparam int unsigned RB_MSB = 18;
  localparam int unsigned RB_LSB = 14;

  localparam int unsigned FUNC_IMM_BIT = 0;
  localparam int unsigned FUNC_SUB_BIT = 1;

  localparam logic [1:0] EXT_ALU_IMM = 2'b00;
  localparam logic [1:0] EXT_MEM_OFF = 2'b01;
  localparam logic [1:0] EXT_BR_TGT  = 2'b10;
  localparam logic [1:0] EXT_REG_REG = 2'b11;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_BR_WAIT = 1'b1
  } issue_state_e;

endpackage

// File: rtl/id_issue_ctrl_if.sv
// Bundle of the IF/ID-facing and ID/EX-facing signals of id_issue_ctrl.
// master: drives the instruction, valid, backend stall and branch result.
// slave : the issue controller; returns stall/flush, decode selects and
//         the registered ID/EX tag plus the debug busy mask.
interface id_issue_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5
) ();
  logic                  if_valid;
  logic [31:0]           instruction;
  logic                  stall_in;
  logic                  branch_taken;
  logic                  id_stall;
  logic                  flush_if;
  logic                  rb_selector;
  logic [1:0]            ext_selector;
  logic                  issue_valid;
  logic                  reg_we_ex;
  logic [REG_ADDR_W-1:0] rw_ex;
  logic [31:0]           busy_mask;

  modport master (
    output if_valid, instruction, stall_in, branch_taken,
    input  id_stall, flush_if, rb_selector, ext_selector,
    input  issue_valid, reg_we_ex, rw_ex, busy_mask
  );

  modport slave (
    input  if_valid, instruction, stall_in, branch_taken,
    output id_stall, flush_if, rb_selector, ext_selector,
    output issue_valid, reg_we_ex, rw_ex, busy_mask
  );
endinterface

// File: rtl/id_issue_ctrl_scoreboard.sv
// In-flight writer tracker for the ID stage.
// A PIPE_DEPTH-deep shift of {valid, rd, is_cmp}; entry 0 receives the
// issued register writer or CMP, otherwise a bubble. The oldest entry drops
// off the end, which is when its write becomes visible to ID.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   advance_i       shift enable (low while the backend is stalled)
//   push_i          issued instruction writes a register or the flags
//   push_rd_i       destination register of the pushed entry
//   push_is_cmp_i   pushed entry is a flag writer (CMP)
//   src_i/src_used_i  up to three register sources and their use bits
//   use_flags_i     instruction reads the flags (conditional branch)
//   hazard_o        a used source or the flags are still pending
//   busy_mask_o     pending-write bit per register
module id_scoreboard
  import asip_isa_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned PIPE_DEPTH = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       advance_i,
  input  logic                       push_i,
  input  logic [REG_ADDR_W-1:0]      push_rd_i,
  input  logic                       push_is_cmp_i,
  input  logic [2:0][REG_ADDR_W-1:0] src_i,
  input  logic [2:0]                 src_used_i,
  input  logic                       use_flags_i,
  output logic                       hazard_o,
  output logic [31:0]                busy_mask_o
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_cmp;
  } sb_entry_t;

  sb_entry_t sb_q [PIPE_DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) sb_q[i] <= '0;
    end else if (advance_i) begin
      sb_q[0] <= push_i ? sb_entry_t'{valid: 1'b1, rd: push_rd_i, is_cmp: push_is_cmp_i}
                        : sb_entry_t'('0);
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  // Mask is rebuilt from the live entries so a younger write to the same
  // register keeps its bit when an older one retires.
  always_comb begin
    busy_mask_o = '0;
    hazard_o    = 1'b0;
    for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
      if (sb_q[i].valid && !sb_q[i].is_cmp) begin
        busy_mask_o[sb_q[i].rd] = 1'b1;
        for (int unsigned s = 0; s < 3; s++) begin
          if (src_used_i[s] && (src_i[s] == sb_q[i].rd)) hazard_o = 1'b1;
        end
      end
      if (sb_q[i].valid && sb_q[i].is_cmp && use_flags_i) hazard_o = 1'b1;
    end
  end

endmodule

// File: rtl/id_issue_ctrl.sv
// ID-stage issue/hazard controller.
// Decodes the IF/ID instruction, checks it against the scoreboard, issues it
// into ID/EX when clear, and runs the branch-bubble FSM.
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   bus     id_issue_ctrl_if slave: if_valid, instruction, stall_in,
//           branch_taken in; id_stall, flush_if, rb_selector, ext_selector,
//           issue_valid, reg_we_ex, rw_ex, busy_mask out
module id_issue_ctrl
  import asip_isa_pkg::*;
#(
  parameter int unsigned REG_ADDR_W     = 5,
  parameter int unsigned PIPE_DEPTH     = 3,
  parameter int unsigned BRANCH_PENALTY = 2
) (
  input  logic           clk,
  input  logic           reset,
  id_issue_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(BRANCH_PENALTY + 1);

  opcode_e                     op;
  logic [REG_ADDR_W-1:0]       rf;
  logic [2:0][REG_ADDR_W-1:0]  src;
  logic [2:0]                  src_used;
  logic                        use_flags;
  logic                        is_writer;
  logic                        is_cmp;
  logic                        is_branch;
  logic                        is_jmp;
  logic                        rb_sel;
  logic [1:0]                  ext_sel;
  logic                        hazard;
  logic                        issue;
  logic                        flush;

  issue_state_e                state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        jmp_q, jmp_d;
  logic                        issue_valid_q;
  logic                        reg_we_q;
  logic [REG_ADDR_W-1:0]       rw_q;

  assign op     = opcode_e'(bus.instruction[OP_MSB:OP_LSB]);
  assign rf     = bus.instruction[RF_MSB:RF_LSB];
  assign src[0] = bus.instruction[RA_MSB:RA_LSB];
  assign src[1] = bus.instruction[RB_MSB:RB_LSB];
  assign src[2] = rf;

  // Decode; src slot 2 is the rf field, read through port B by STR.
  always_comb begin
    src_used  = '0;
    use_flags = 1'b0;
    is_writer = 1'b0;
    is_cmp    = 1'b0;
    is_branch = 1'b0;
    is_jmp    = 1'b0;
    rb_sel    = 1'b0;
    ext_sel   = EXT_ALU_IMM;
    unique case (op)
      OP_ALU: begin
        is_writer   = 1'b1;
        src_used[0] = 1'b1;
        src_used[1] = !bus.instruction[FUNC_IMM_BIT];
        ext_sel     = bus.instruction[FUNC_IMM_BIT] ? EXT_ALU_IMM : EXT_REG_REG;
      end
      OP_CMP: begin
        is_cmp   = 1'b1;
        src_used = 3'b011;
        ext_sel  = EXT_REG_REG;
      end
      OP_LDR: begin
        is_writer   = 1'b1;
        src_used[0] = 1'b1;
        ext_sel     = EXT_MEM_OFF;
      end
      OP_STR: begin
        src_used = 3'b101;
        rb_sel   = 1'b1;
        ext_sel  = EXT_MEM_OFF;
      end
      OP_JEQ, OP_JNE: begin
        is_branch = 1'b1;
        use_flags = 1'b1;
        ext_sel   = EXT_BR_TGT;
      end
      OP_JMP: begin
        is_branch = 1'b1;
        is_jmp    = 1'b1;
        ext_sel   = EXT_BR_TGT;
      end
      default: ;
    endcase
  end

  id_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_scoreboard (
    .clk_i         (clk),
    .rst_ni        (reset),
    .advance_i     (!bus.stall_in),
    .push_i        (issue && (is_writer || is_cmp)),
    .push_rd_i     (rf),
    .push_is_cmp_i (is_cmp),
    .src_i         (src),
    .src_used_i    (src_used),
    .use_flags_i   (use_flags),
    .hazard_o      (hazard),
    .busy_mask_o   (bus.busy_mask)
  );

  assign issue = (state_q == ST_RUN) && bus.if_valid && !hazard && !bus.stall_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    jmp_d   = jmp_q;
    flush   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (issue && is_branch) begin
          state_d = ST_BR_WAIT;
          cnt_d   = CNT_W'(BRANCH_PENALTY - 1);
          jmp_d   = is_jmp;
        end
      end
      ST_BR_WAIT: begin
        if (!bus.stall_in) begin
          // JMP always redirects; its flush lands on the final bubble cycle.
          flush = bus.branch_taken || (jmp_q && (cnt_q == '0));
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      jmp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      jmp_q   <= jmp_d;
    end
  end

  // ID/EX tag: bubble on non-issue cycles, held while the backend stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid_q <= 1'b0;
      reg_we_q      <= 1'b0;
      rw_q          <= '0;
    end else if (!bus.stall_in) begin
      issue_valid_q <= issue;
      reg_we_q      <= issue && is_writer;
      rw_q          <= (issue && is_writer) ? rf : '0;
    end
  end

  assign bus.id_stall     = (bus.if_valid && !issue) || (state_q == ST_BR_WAIT) || bus.stall_in;
  assign bus.flush_if     = flush;
  assign bus.rb_selector  = rb_sel;
  assign bus.ext_selector = ext_sel;
  assign bus.issue_valid  = issue_valid_q;
  assign bus.reg_we_ex    = reg_we_q;
  assign bus.rw_ex        = rw_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
module tb_id_issue_ctrl;

  localparam logic [31:0] I_ADD  = 32'h01100029; // ADD R1,R2,#10
  localparam logic [31:0] I_SUB  = 32'h02090002; // SUB R2,R1,R4
  localparam logic [31:0] I_CMP  = 32'h20004002; // CMP R0,R1
  localparam logic [31:0] I_JEQ  = 32'h80000000;
  localparam logic [31:0] I_ADD6 = 32'h06000001; // ADD R6,R0,#0
  localparam logic [31:0] I_STR  = 32'h66380020; // STR R6,32(R7)
  localparam logic [31:0] I_JMP  = 32'hC0000010;
  localparam logic [31:0] I_NOP  = 32'hE0000000;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  id_issue_ctrl_if #(.REG_ADDR_W(5)) bus ();

  id_issue_ctrl #(
    .REG_ADDR_W     (5),
    .PIPE_DEPTH     (3),
    .BRANCH_PENALTY (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] ins);
    bus.if_valid    = 1'b1;
    bus.instruction = ins;
    #1;
  endtask

  task automatic idle(input int n);
    bus.if_valid    = 1'b0;
    bus.instruction = I_NOP;
    repeat (n) tick();
  endtask

  // Present a hazarded instruction for n stall cycles, then expect it to issue.
  task automatic stall_then_clear(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_stall"}, 32'(bus.id_stall), 32'd1);
      tick();
    end
    chk({tag, "_clear"}, 32'(bus.id_stall), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.if_valid     = 1'b0;
    bus.instruction  = I_NOP;
    bus.stall_in     = 1'b0;
    bus.branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
    chk("rst_reg_we",      32'(bus.reg_we_ex),   32'd0);
    chk("rst_rw",          32'(bus.rw_ex),       32'd0);
    chk("rst_busy",        bus.busy_mask,        32'd0);
    chk("rst_stall",       32'(bus.id_stall),    32'd0);
    chk("rst_flush",       32'(bus.flush_if),    32'd0);
    reset = 1'b1;
    tick();

    bus.branch_taken = 1'b1;
    #1;
    chk("bt_ignored_run", 32'(bus.flush_if), 32'd0);
    bus.branch_taken = 1'b0;

    // ADD then dependent SUB
    present(I_ADD);
    chk("add_nostall", 32'(bus.id_stall),     32'd0);
    chk("add_ext",     32'(bus.ext_selector), 32'd0);
    chk("add_rbsel",   32'(bus.rb_selector),  32'd0);
    tick();
    chk("add_iv",   32'(bus.issue_valid), 32'd1);
    chk("add_we",   32'(bus.reg_we_ex),   32'd1);
    chk("add_rw",   32'(bus.rw_ex),       32'd1);
    chk("add_busy", bus.busy_mask,        32'h2);
    present(I_SUB);
    chk("sub_ext", 32'(bus.ext_selector), 32'd3);
    chk("sub_stall0", 32'(bus.id_stall), 32'd1);
    tick();
    chk("sub_bubble_iv", 32'(bus.issue_valid), 32'd0);
    chk("sub_bubble_rw", 32'(bus.rw_ex),       32'd0);
    stall_then_clear("sub", 2);
    tick();
    chk("sub_iv",   32'(bus.issue_valid), 32'd1);
    chk("sub_rw",   32'(bus.rw_ex),       32'd2);
    chk("sub_we",   32'(bus.reg_we_ex),   32'd1);
    chk("sub_busy", bus.busy_mask,        32'h4);
    idle(3);
    chk("drain1_busy", bus.busy_mask, 32'd0);

    // CMP then JEQ, taken
    present(I_CMP);
    chk("cmp_ext", 32'(bus.ext_selector), 32'd3);
    tick();
    chk("cmp_iv",   32'(bus.issue_valid), 32'd1);
    chk("cmp_we",   32'(bus.reg_we_ex),   32'd0);
    chk("cmp_busy", bus.busy_mask,        32'd0);
    present(I_JEQ);
    chk("jeq_ext", 32'(bus.ext_selector), 32'd2);
    stall_then_clear("jeq", 3);
    tick();
    chk("jeq_iv", 32'(bus.issue_valid), 32'd1);
    chk("jeq_we", 32'(bus.reg_we_ex),   32'd0);
    present(I_NOP);
    chk("jeq_bw1_stall", 32'(bus.id_stall), 32'd1);
    chk("jeq_bw1_noflush", 32'(bus.flush_if), 32'd0);
    bus.branch_taken = 1'b1;
    #1;
    chk("jeq_taken_flush", 32'(bus.flush_if), 32'd1);
    tick();
    bus.branch_taken = 1'b0;
    #1;
    chk("jeq_bw2_iv",    32'(bus.issue_valid), 32'd0);
    chk("jeq_bw2_stall", 32'(bus.id_stall),    32'd1);
    chk("jeq_bw2_flush", 32'(bus.flush_if),    32'd0);
    tick();
    chk("jeq_run_stall", 32'(bus.id_stall), 32'd0);
    idle(3);

    // STR reading a pending R6
    present(I_ADD6);
    tick();
    chk("r6_busy", bus.busy_mask, 32'h40);
    present(I_STR);
    chk("str_rbsel", 32'(bus.rb_selector),  32'd1);
    chk("str_ext",   32'(bus.ext_selector), 32'd1);
    stall_then_clear("str", 3);
    tick();
    chk("str_iv", 32'(bus.issue_valid), 32'd1);
    chk("str_we", 32'(bus.reg_we_ex),   32'd0);
    idle(3);

    // JMP: immediate issue, forced flush on the last bubble
    present(I_JMP);
    chk("jmp_ext",     32'(bus.ext_selector), 32'd2);
    chk("jmp_nostall", 32'(bus.id_stall),     32'd0);
    tick();
    chk("jmp_iv", 32'(bus.issue_valid), 32'd1);
    chk("jmp_we", 32'(bus.reg_we_ex),   32'd0);
    bus.if_valid = 1'b0;
    #1;
    chk("jmp_bw1_flush", 32'(bus.flush_if), 32'd0);
    chk("jmp_bw1_stall", 32'(bus.id_stall), 32'd1);
    tick();
    chk("jmp_bw2_flush", 32'(bus.flush_if), 32'd1);
    tick();
    chk("jmp_run_flush", 32'(bus.flush_if), 32'd0);
    chk("jmp_run_stall", 32'(bus.id_stall), 32'd0);
    idle(2);

    // Backend stall during a pending hazard
    present(I_ADD);
    tick();
    present(I_SUB);
    bus.stall_in = 1'b1;
    #1;
    chk("bs_stall", 32'(bus.id_stall), 32'd1);
    tick();
    chk("bs_hold_iv1",   32'(bus.issue_valid), 32'd1);
    chk("bs_hold_busy1", bus.busy_mask,        32'h2);
    tick();
    chk("bs_hold_rw2",   32'(bus.rw_ex),       32'd1);
    chk("bs_hold_busy2", bus.busy_mask,        32'h2);
    bus.stall_in = 1'b0;
    #1;
    chk("bs_sub_stall0", 32'(bus.id_stall), 32'd1);
    tick();
    chk("bs_bubble_iv", 32'(bus.issue_valid), 32'd0);
    stall_then_clear("bs_sub", 2);
    tick();
    chk("bs_sub_rw", 32'(bus.rw_ex), 32'd2);
    idle(3);

    // Async reset while entries are pending and the FSM is in BR_WAIT
    present(I_ADD);
    tick();
    present(I_JMP);
    tick();
    bus.if_valid = 1'b0;
    #1;
    chk("pre_rst_busy",  bus.busy_mask,     32'h2);
    chk("pre_rst_stall", 32'(bus.id_stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_busy",  bus.busy_mask,        32'd0);
    chk("arst_iv",    32'(bus.issue_valid), 32'd0);
    chk("arst_stall", 32'(bus.id_stall),    32'd0);
    reset = 1'b1;
    tick();
    chk("post_rst_busy", bus.busy_mask,        32'd0);
    chk("post_rst_iv",   32'(bus.issue_valid), 32'd0);
    present(I_ADD);
    chk("post_rst_run", 32'(bus.id_stall), 32'd0);
    tick();
    chk("post_rst_issue", 32'(bus.issue_valid), 32'd1);
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
